data_memory_responder: RTL and testbench

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/data_memory_responder_pkg.sv | 31 +++
 rtl/data_memory_array.sv | 37 +++
 rtl/data_memory_responder.sv | 134 +++++++++++++
 tb/tb_data_memory_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// byte-lane mask width and the load/store funct3 codes used by requesters.
package data_memory_responder_pkg;

  localparam int LANES       = 4;
  localparam int LATENCY_MAX = 15;

  typedef logic [LANES-1:0] lane_mask_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  // Load/store funct3 encodings; lane selection and extension stay with the requester.
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  // A request must carry exactly one of load/store.
  function automatic logic op_conflict(input logic rd, input logic wr);
    return rd == wr;
  endfunction

endpackage

// File: rtl/data_memory_array.sv
// Byte-lane word storage: one 8-bit RAM per lane, synchronous write with
// per-lane enable and a registered read that holds between read strobes.
module data_memory_array
  import data_memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] word_index,
  input  logic [3:0]            lane_we,
  input  logic                  read_en,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] lane_mem [0:DEPTH-1];
      logic [7:0] lane_q_reg;

      always_ff @(posedge clk) begin
        if (lane_we[gi]) begin
          lane_mem[word_index] <= write_data[8*gi +: 8];
        end
        if (read_en) begin
          lane_q_reg <= lane_mem[word_index];
        end
      end

      assign read_data[8*gi +: 8] = lane_q_reg;
    end
  endgenerate

endmodule

// File: rtl/data_memory_responder.sv
// Word-addressed data memory with a valid/ready request side, a fixed access
// latency for legal requests and an immediate error response for illegal ones.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_mask,
  input  logic        misaligned,
  output logic        response_valid,
  input  logic        response_ready,
  output logic [31:0] read_data,
  output logic        response_error,
  output logic        busy
);

  localparam logic [3:0] LOAD_COUNT = 4'(LATENCY - 1);

  state_t                state_reg;
  logic [3:0]            count_reg;
  logic [ADDR_WIDTH-1:0] index_reg;
  logic [31:0]           wdata_reg;
  lane_mask_t            mask_reg;
  logic                  is_load_reg;
  logic                  request_ready_reg;
  logic                  response_valid_reg;
  logic                  error_reg;
  logic                  busy_reg;

  logic        accept;
  logic        illegal;
  logic        do_access;
  logic [3:0]  lane_we;
  logic        read_en;
  logic [31:0] array_q;
  logic        unused_addr_bits;

  assign accept  = request_valid && request_ready_reg;
  assign illegal = misaligned || op_conflict(memory_read, memory_write) ||
                   (|address[31:ADDR_WIDTH+2]);

  // The storage operation fires only on the final ACCESS edge, so a reset
  // that lands earlier abandons the request without touching memory.
  assign do_access = (state_reg == ACCESS) && (count_reg == 4'd0);
  assign lane_we   = (do_access && !is_load_reg) ? mask_reg : 4'b0000;
  assign read_en   = do_access && is_load_reg;

  // The byte offset is the requester's concern; only the word index is used.
  assign unused_addr_bits = &{1'b0, address[1:0]};

  data_memory_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk        (clk),
    .word_index (index_reg),
    .lane_we    (lane_we),
    .read_en    (read_en),
    .write_data (wdata_reg),
    .read_data  (array_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg          <= IDLE;
      count_reg          <= 4'd0;
      index_reg          <= '0;
      wdata_reg          <= 32'd0;
      mask_reg           <= '0;
      is_load_reg        <= 1'b0;
      request_ready_reg  <= 1'b1;
      response_valid_reg <= 1'b0;
      error_reg          <= 1'b0;
      busy_reg           <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            index_reg         <= address[ADDR_WIDTH+1:2];
            wdata_reg         <= write_data;
            mask_reg          <= write_mask;
            is_load_reg       <= memory_read;
            request_ready_reg <= 1'b0;
            busy_reg          <= 1'b1;
            if (illegal) begin
              state_reg          <= RESPOND;
              error_reg          <= 1'b1;
              response_valid_reg <= 1'b1;
            end else begin
              state_reg <= ACCESS;
              count_reg <= LOAD_COUNT;
            end
          end
        end
        ACCESS: begin
          if (count_reg == 4'd0) begin
            state_reg          <= RESPOND;
            response_valid_reg <= 1'b1;
          end else begin
            count_reg <= count_reg - 4'd1;
          end
        end
        RESPOND: begin
          // Ready rises only after the handshake edge, so nothing is accepted on it.
          if (response_ready) begin
            state_reg          <= IDLE;
            response_valid_reg <= 1'b0;
            error_reg          <= 1'b0;
            busy_reg           <= 1'b0;
            request_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign request_ready  = request_ready_reg;
  assign response_valid = response_valid_reg;
  assign response_error = error_reg;
  assign busy           = busy_reg;
  assign read_data      = (state_reg == RESPOND && is_load_reg && !error_reg) ? array_q : 32'd0;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder with a response scoreboard and a
// word-level reference model of the storage.
module tb_data_memory_responder;

  localparam int AW  = 10;
  localparam int LAT = 4;

  logic        clk;
  logic        reset_n;
  logic        request_valid;
  logic        request_ready;
  logic        memory_read;
  logic        memory_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [3:0]  write_mask;
  logic        misaligned;
  logic        response_valid;
  logic        response_ready;
  logic [31:0] read_data;
  logic        response_error;
  logic        busy;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [int];
  int          tests = 0;
  int          fails = 0;

  data_memory_responder #(
    .ADDR_WIDTH(AW),
    .LATENCY   (LAT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .request_valid (request_valid),
    .request_ready (request_ready),
    .memory_read   (memory_read),
    .memory_write  (memory_write),
    .address       (address),
    .write_data    (write_data),
    .write_mask    (write_mask),
    .misaligned    (misaligned),
    .response_valid(response_valid),
    .response_ready(response_ready),
    .read_data     (read_data),
    .response_error(response_error),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called at #1 after a rising edge with the DUT idle; returns in the same phase.
  task automatic transact(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] mask, input logic mis, input int hold);
    exp_t        e;
    logic        bad;
    int          idx;
    int          lat;
    logic        seen;
    logic [31:0] cur;
    logic [31:0] upper;

    upper = addr >> (AW + 2);
    bad   = mis || (rd == wr) || (upper != 32'd0);
    idx   = int'(addr[AW+1:2]);
    e.err = bad;
    // Illegal requests respond on the accepting edge itself.
    e.lat  = bad ? 0 : LAT;
    e.data = 32'd0;
    if (!bad) begin
      cur = model.exists(idx) ? model[idx] : 32'd0;
      if (rd) begin
        e.data = cur;
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (mask[b]) cur[8*b +: 8] = data[8*b +: 8];
        end
        model[idx] = cur;
      end
    end
    exp_q.push_back(e);

    check1($sformatf("%s.ready_before", tag), request_ready, 1'b1);
    request_valid = 1'b1;
    memory_read   = rd;
    memory_write  = wr;
    address       = addr;
    write_data    = data;
    write_mask    = mask;
    misaligned    = mis;
    @(posedge clk); #1;
    request_valid = 1'b0;
    memory_read   = 1'b0;
    memory_write  = 1'b0;
    misaligned    = 1'b0;
    check1($sformatf("%s.busy", tag), busy, 1'b1);
    check1($sformatf("%s.ready_busy", tag), request_ready, 1'b0);

    seen = 1'b0;
    lat  = 0;
    for (int n = 0; n <= 40; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      if (response_valid === 1'b1) begin
        seen = 1'b1;
        lat  = n;
        break;
      end
    end
    e = exp_q.pop_front();
    if (!seen) begin
      check1($sformatf("%s.response_timeout", tag), response_valid, 1'b1);
      return;
    end
    check32($sformatf("%s.latency", tag), 32'(lat), 32'(e.lat));
    check32($sformatf("%s.read_data", tag), read_data, e.data);
    check1($sformatf("%s.error", tag), response_error, e.err);

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check1($sformatf("%s.hold%0d_valid", tag, h), response_valid, 1'b1);
      check32($sformatf("%s.hold%0d_data", tag, h), read_data, e.data);
      check1($sformatf("%s.hold%0d_error", tag, h), response_error, e.err);
      check1($sformatf("%s.hold%0d_ready", tag, h), request_ready, 1'b0);
    end

    response_ready = 1'b1;
    @(posedge clk); #1;
    response_ready = 1'b0;
    check1($sformatf("%s.valid_after", tag), response_valid, 1'b0);
    check1($sformatf("%s.ready_after", tag), request_ready, 1'b1);
    check1($sformatf("%s.busy_after", tag), busy, 1'b0);

    $display("[TB] txn %s rd=%0d wr=%0d addr=%h data=%h mask=%b mis=%0d -> exp_data=%h exp_err=%0d edges=%0d",
             tag, rd, wr, addr, data, mask, mis, e.data, e.err, lat);
  endtask

  initial begin
    logic [31:0] rnd_a;
    logic [31:0] rnd_b;
    logic [3:0]  rnd_m;
    logic [31:0] waddr;

    reset_n        = 1'b0;
    request_valid  = 1'b0;
    memory_read    = 1'b0;
    memory_write   = 1'b0;
    address        = 32'd0;
    write_data     = 32'd0;
    write_mask     = 4'd0;
    misaligned     = 1'b0;
    response_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check1("reset.ready", request_ready, 1'b1);
    check1("reset.valid", response_valid, 1'b0);
    check1("reset.error", response_error, 1'b0);
    check1("reset.busy", busy, 1'b0);
    check32("reset.read_data", read_data, 32'd0);

    // Full store then load.
    transact("st_deadbeef", 1'b0, 1'b1, 32'h0000_00F0, 32'hDEAD_BEEF, 4'b1111, 1'b0, 0);
    transact("ld_deadbeef", 1'b1, 1'b0, 32'h0000_00F0, 32'h0, 4'b0000, 1'b0, 0);

    // Single-lane store.
    transact("st_cccc", 1'b0, 1'b1, 32'h0000_00F0, 32'hCCCC_CCCC, 4'b1111, 1'b0, 0);
    transact("st_lane1", 1'b0, 1'b1, 32'h0000_00F1, 32'hEFEF_EFEF, 4'b0010, 1'b0, 0);
    transact("ld_lane1", 1'b1, 1'b0, 32'h0000_00F0, 32'h0, 4'b0000, 1'b0, 0);

    // Illegal requests leave storage alone.
    transact("st_misaligned", 1'b0, 1'b1, 32'h0000_00F1, 32'h1234_5678, 4'b1111, 1'b1, 0);
    transact("rdwr_both", 1'b1, 1'b1, 32'h0000_00F0, 32'h5555_5555, 4'b1111, 1'b0, 0);
    transact("rdwr_none", 1'b0, 1'b0, 32'h0000_00F0, 32'h5555_5555, 4'b1111, 1'b0, 0);
    transact("st_out_of_range", 1'b0, 1'b1, 32'h0000_1000, 32'h7777_7777, 4'b1111, 1'b0, 0);
    transact("ld_out_of_range", 1'b1, 1'b0, 32'h8000_00F0, 32'h0, 4'b0000, 1'b0, 0);
    transact("ld_after_illegal", 1'b1, 1'b0, 32'h0000_00F0, 32'h0, 4'b0000, 1'b0, 0);

    // Empty mask is legal and changes nothing.
    transact("st_mask0", 1'b0, 1'b1, 32'h0000_00F0, 32'hFFFF_FFFF, 4'b0000, 1'b0, 0);
    transact("ld_mask0", 1'b1, 1'b0, 32'h0000_00F0, 32'h0, 4'b0000, 1'b0, 0);

    // Back-pressure on the response.
    transact("ld_hold3", 1'b1, 1'b0, 32'h0000_00F0, 32'h0, 4'b0000, 1'b0, 3);
    transact("st_hold2", 1'b0, 1'b1, 32'h0000_0010, 32'h0BAD_F00D, 4'b1111, 1'b0, 2);
    transact("err_hold2", 1'b0, 1'b1, 32'h0000_0010, 32'h0, 4'b1111, 1'b1, 2);

    // Address boundaries.
    transact("st_first", 1'b0, 1'b1, 32'h0000_0000, 32'h0102_0304, 4'b1111, 1'b0, 0);
    transact("st_last", 1'b0, 1'b1, 32'h0000_0FFC, 32'hA5A5_5A5A, 4'b1111, 1'b0, 0);
    transact("ld_first", 1'b1, 1'b0, 32'h0000_0003, 32'h0, 4'b0000, 1'b0, 0);
    transact("ld_last", 1'b1, 1'b0, 32'h0000_0FFC, 32'h0, 4'b0000, 1'b0, 0);

    // Random data and masks across a handful of words.
    for (int i = 0; i < 6; i++) begin
      rnd_a = $urandom;
      rnd_b = $urandom;
      rnd_m = 4'($urandom_range(0, 15));
      waddr = 32'h0000_0200 + 32'(i * 4);
      transact($sformatf("rnd%0d_full", i), 1'b0, 1'b1, waddr, rnd_a, 4'b1111, 1'b0, 0);
      transact($sformatf("rnd%0d_part", i), 1'b0, 1'b1, waddr, rnd_b, rnd_m, 1'b0, 0);
      transact($sformatf("rnd%0d_load", i), 1'b1, 1'b0, waddr, 32'h0, 4'b0000, 1'b0, 0);
    end

    // Reset in the second ACCESS cycle abandons the store.
    transact("st_ones", 1'b0, 1'b1, 32'h0000_00F0, 32'h1111_1111, 4'b1111, 1'b0, 0);
    request_valid = 1'b1;
    memory_write  = 1'b1;
    address       = 32'h0000_00F0;
    write_data    = 32'hAAAA_AAAA;
    write_mask    = 4'b1111;
    @(posedge clk); #1;
    request_valid = 1'b0;
    memory_write  = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check1("rst_access.valid", response_valid, 1'b0);
    check1("rst_access.error", response_error, 1'b0);
    check1("rst_access.busy", busy, 1'b0);
    check32("rst_access.read_data", read_data, 32'd0);
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check1("rst_access.ready", request_ready, 1'b1);
    $display("[TB] txn rst_access: reset pulsed during ACCESS of store AAAAAAAA to 000000f0");
    transact("ld_after_reset", 1'b1, 1'b0, 32'h0000_00F0, 32'h0, 4'b0000, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
